lap_capture: RTL
================

// Module: lap_capture
// PURPOSE
//  Producer for the lap stash: turns a raw LAP push-button into exactly one validated
//  8-bit lap sample per press. The sample is taken from the running stopwatch's BCD
//  seconds value. Sits between the stopwatch counter/button pins and the stash's
//  sample_in / sample_in_valid inputs. Handles synchronisation, debounce, edge-to-pulse
//  conversion and lap numbering.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable cycles required to accept a press or release (10 ms @ 100 MHz)
//  CNT_W            20       debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//  MAX_LAPS         10       lap_count wraps to 0 after MAX_LAPS-1; matches the stash DEPTH
// PORTS
//  clk              in   1  system clock, 100 MHz
//  reset            in   1  asynchronous, active-low reset (0 = reset)
//  lap_btn          in   1  raw, asynchronous, bouncing LAP button (1 = pressed)
//  running          in   1  stopwatch running flag, synchronous to clk
//  time_bcd         in   8  stopwatch seconds, two BCD digits {tens,units}, 00..99
//  clear_laps       in   1  one-cycle pulse; clears lap_count (and prev_time)
//  sample_out       out  8  captured lap value, BCD; feeds stash sample_in
//  sample_out_valid out  1  one-cycle strobe; feeds stash sample_in_valid
//  lap_count        out  4  number of laps emitted, modulo MAX_LAPS
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, FSM=IDLE, debounce counter 0,
//   synchroniser flops 0, prev_time 00. Asserting reset mid-press aborts it immediately;
//   no strobe is emitted.
//  lap_btn passes through a 2-flop synchroniser -> btn_s. The FSM uses btn_s only.
//  FSM states and transitions:
//   IDLE     : if btn_s=1 -> PRESS with cnt=0.
//   PRESS    : btn_s=1 -> cnt++. btn_s=0 -> IDLE (bounce). cnt==DEBOUNCE_CYCLES-1 with btn_s=1 -> FIRE.
//   FIRE     : lasts one cycle. If running=1: sample_out<=capture value,
//              sample_out_valid=1 for this cycle only, lap_count++ (wraps at MAX_LAPS).
//              If running=0: press is consumed, with no strobe and no count.
//              Next state is always RELEASE, cnt=0.
//   RELEASE  : btn_s=0 -> cnt++. btn_s=1 -> cnt=0. cnt==DEBOUNCE_CYCLES-1 with btn_s=0 -> IDLE.
//  Latency: sample_out_valid is high on the (DEBOUNCE_CYCLES+3)-th rising edge after lap_btn
//   is first sampled high, provided lap_btn stays high throughout.
//  Exactly one strobe per debounced press; holding the button never repeats the strobe.
//  sample_out holds its last value between strobes. It is valid only while the strobe is high.
//  clear_laps: lap_count<=0 and prev_time<=00 on the next edge. If clear_laps coincides with
//   FIRE, the capture wins for sample_out, and lap_count ends at 1.
//  running/time_bcd are sampled in FIRE only; both are ignored in all other states.
//  time_bcd digits >9 are out of contract; the block passes them through unchecked.
// CONFIGURATION
//  `LAP_SPLIT_EN defined: capture value = split = (time_bcd - prev_time) mod 100, computed
//   in BCD with a per-digit borrow (units<prev -> +10 and borrow; the tens digit wraps mod 10).
//   prev_time<=time_bcd on every emitted strobe. First lap after reset/clear = time_bcd.
//   Example: prev 95, now 03 -> 08.
//  Not defined: capture value = time_bcd (absolute). prev_time and the subtractor are not built.
// STRUCTURE
//  stopwatch_defs.vh (shared include): FSM state encodings (IDLE/PRESS/FIRE/RELEASE, 2 bits),
//   BCD_W=8, and the BCD digit-subtract helper function, shared with the display path.
//  Sub-module btn_debounce: synchroniser + counter. Outputs a stable level and a one-cycle
//   rise pulse, reusable for the START/STOP and NEXT buttons.
//   lap_capture keeps the FIRE decision, the capture logic and lap_count.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, MAX_LAPS=10)
//  1. running=1, time_bcd=8'h37, clean press held 20 cycles -> single strobe on edge 7,
//     sample_out=8'h37, lap_count=1; no further strobe while held or on release.
//  2. Bouncy press 1,0,1,1,0 then steady high -> no strobe until 4 consecutive stable-high
//     cycles; exactly one strobe in total.
//  3. running=0, press -> no strobe, lap_count stays 0; release, set running=1, press
//     -> strobe.
//  4. 11 presses with time_bcd=8'h00..8'h10 -> lap_count sequence 1..9,0,1; sample_out
//     tracks time_bcd each press.
//  5. `LAP_SPLIT_EN: presses at 8'h12, 8'h30, then 8'h05 -> sample_out 8'h12, 8'h18, 8'h75;
//     clear_laps, then press at 8'h40 -> 8'h40.
//  6. reset driven low in PRESS, cycle 2 -> outputs 0 immediately; after release with
//     button held, a full debounce is needed before the strobe.

Source files
------------

// File: rtl/lap_capture_pkg.sv
// Shared definitions for the lap capture path.
//  - lap_state_e : debounce FSM state encodings (2 bits)
//  - BCD_W       : width of a two-digit BCD value
//  - bcd_sub     : two-digit BCD subtract, result mod 100
package lap_capture_pkg;

  localparam int unsigned BCD_W = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPress   = 2'd1,
    StFire    = 2'd2,
    StRelease = 2'd3
  } lap_state_e;

  // (a - b) mod 100 on BCD operands. The units digit borrows from the tens;
  // the tens digit wraps mod 10. Digits above 9 are not checked.
  function automatic logic [BCD_W-1:0] bcd_sub(input logic [BCD_W-1:0] a,
                                               input logic [BCD_W-1:0] b);
    logic [4:0] ua, ub, ta, tb;
    logic [4:0] units, tens;
    logic       borrow;
    ua = {1'b0, a[3:0]};
    ub = {1'b0, b[3:0]};
    borrow = (ua < ub);
    units  = borrow ? (ua + 5'd10 - ub) : (ua - ub);
    ta = {1'b0, a[7:4]};
    tb = {1'b0, b[7:4]} + {4'd0, borrow};
    tens = (ta < tb) ? (ta + 5'd10 - tb) : (ta - tb);
    return {tens[3:0], units[3:0]};
  endfunction

endpackage

// File: rtl/lap_capture_if.sv
// Lap sample bus from lap_capture to the lap stash.
//  sample_out       : captured lap value (BCD)
//  sample_out_valid : one-cycle strobe, sample_out valid only while high
//  lap_count        : laps emitted, modulo MAX_LAPS
// Modports: master (producer), slave (stash side).
interface lap_capture_if;
  import lap_capture_pkg::*;

  logic [BCD_W-1:0] sample_out;
  logic             sample_out_valid;
  logic [3:0]       lap_count;

  modport master (output sample_out, output sample_out_valid, output lap_count);
  modport slave  (input  sample_out, input  sample_out_valid, input  lap_count);
endinterface

// File: rtl/lap_capture_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser plus a counting debounce FSM.
// Ports:
//  clk, reset : clock, asynchronous active-low reset
//  btn_raw    : raw asynchronous button (1 = pressed)
//  level      : debounced level, high from the accepted press until release is accepted
//  rise       : one-cycle pulse when a press is accepted
module lap_capture_btn_debounce
  import lap_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  lap_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign btn_s = sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b00;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (btn_s) state_d = StPress;
      end
      StPress: begin
        if (!btn_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StFire;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFire: begin
        state_d = StRelease;
        cnt_d   = '0;
      end
      StRelease: begin
        // Any high sample restarts the release window
        if (btn_s) begin
          cnt_d = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign rise  = (state_q == StFire);
  assign level = (state_q == StFire) || (state_q == StRelease);

endmodule

// File: rtl/lap_capture.sv
// Lap sample producer: debounces the LAP button and emits one BCD lap sample per press.
// Ports:
//  clk, reset : 100 MHz clock, asynchronous active-low reset
//  lap_btn    : raw bouncing LAP button
//  running    : stopwatch running flag (sampled only when a press is accepted)
//  time_bcd   : stopwatch seconds {tens,units} BCD
//  clear_laps : one-cycle pulse, clears lap_count and prev_time
//  bus        : master side of lap_capture_if (sample_out, sample_out_valid, lap_count)
// Build option: LAP_SPLIT_EN emits split times (time_bcd - prev_time) instead of absolute time.
module lap_capture
  import lap_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned MAX_LAPS        = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lap_btn,
  input  logic             running,
  input  logic [BCD_W-1:0] time_bcd,
  input  logic             clear_laps,
  lap_capture_if.master    bus
);

  logic             level, rise, strobe;
  logic [BCD_W-1:0] capture;
  logic [BCD_W-1:0] sample_q;
  logic [3:0]       count_q, count_d;

  lap_capture_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(lap_btn),
    .level  (level),
    .rise   (rise)
  );

  // rise only occurs while level is high; level is kept as a qualifier
  assign strobe = rise && level && running;

`ifdef LAP_SPLIT_EN
  logic [BCD_W-1:0] prev_q;

  assign capture = bcd_sub(time_bcd, prev_q);

  // A strobe coinciding with clear_laps still records its own time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          prev_q <= '0;
    else if (strobe)     prev_q <= time_bcd;
    else if (clear_laps) prev_q <= '0;
  end
`else
  assign capture = time_bcd;
`endif

  always_comb begin
    count_d = count_q;
    if (strobe) count_d = (count_q == 4'(MAX_LAPS - 1)) ? 4'd0 : count_q + 4'd1;
    // A clear during the strobe cycle counts that lap as the first
    if (clear_laps) count_d = strobe ? 4'd1 : 4'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q <= '0;
      count_q  <= '0;
    end else begin
      if (strobe) sample_q <= capture;
      count_q <= count_d;
    end
  end

  // The capture is presented in the strobe cycle itself and held afterwards
  assign bus.sample_out       = strobe ? capture : sample_q;
  assign bus.sample_out_valid = strobe;
  assign bus.lap_count        = count_q;

endmodule
